// File: rtl/enigma_pkg.sv
// rtl/enigma_pkg.sv - shared constants, FSM states and rotor tables for the key stepper
package enigma_pkg;

  localparam int LETTER_COUNT = 26;
  localparam int POS_W        = 5;

  typedef logic [POS_W-1:0] pos_t;

  localparam pos_t LAST_POS = 5'd25;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_STEP = 2'd1,
    ST_EMIT = 2'd2
  } state_t;

  // Rotor identifiers I..V
  localparam logic [2:0] ROTOR_I   = 3'd0;
  localparam logic [2:0] ROTOR_II  = 3'd1;
  localparam logic [2:0] ROTOR_III = 3'd2;
  localparam logic [2:0] ROTOR_IV  = 3'd3;
  localparam logic [2:0] ROTOR_V   = 3'd4;

  typedef struct packed {
    logic [2:0] left;
    logic [2:0] middle;
    logic [2:0] right;
  } wheel_order_t;

  // Turnover position of each rotor: I=Q, II=E, III=V, IV=J, V=Z
  function automatic pos_t rotor_notch(input logic [2:0] rotor);
    case (rotor)
      ROTOR_I:   return 5'd16;
      ROTOR_II:  return 5'd4;
      ROTOR_III: return 5'd21;
      ROTOR_IV:  return 5'd9;
      default:   return 5'd25;
    endcase
  endfunction

  // Rotor order (left, middle, right) for each wheel_config code; all 8 codes are legal
  function automatic wheel_order_t wheel_order(input logic [2:0] cfg);
    case (cfg)
      3'd0:    return '{left: ROTOR_I,   middle: ROTOR_II,  right: ROTOR_III};
      3'd1:    return '{left: ROTOR_I,   middle: ROTOR_III, right: ROTOR_II};
      3'd2:    return '{left: ROTOR_II,  middle: ROTOR_I,   right: ROTOR_III};
      3'd3:    return '{left: ROTOR_II,  middle: ROTOR_III, right: ROTOR_I};
      3'd4:    return '{left: ROTOR_III, middle: ROTOR_I,   right: ROTOR_II};
      3'd5:    return '{left: ROTOR_III, middle: ROTOR_II,  right: ROTOR_I};
      3'd6:    return '{left: ROTOR_IV,  middle: ROTOR_II,  right: ROTOR_V};
      default: return '{left: ROTOR_V,   middle: ROTOR_IV,  right: ROTOR_III};
    endcase
  endfunction

  // Advance one position, wrapping Z back to A
  function automatic pos_t pos_inc(input pos_t p);
    return (p == LAST_POS) ? 5'd0 : p + 5'd1;
  endfunction

  // Out-of-range start positions load as A
  function automatic pos_t pos_sanitize(input pos_t p);
    return (p > LAST_POS) ? 5'd0 : p;
  endfunction

endpackage

// File: rtl/key_stepper_rotor_advance.sv
// rtl/key_stepper_rotor_advance.sv - combinational next-position logic for the three rotors
module rotor_advance
  import enigma_pkg::*;
(
  input  logic [4:0] i_pos_r,
  input  logic [4:0] i_pos_m,
  input  logic [4:0] i_pos_l,
  input  logic [4:0] i_notch_r,
  input  logic [4:0] i_notch_m,
  output logic [4:0] o_pos_r,
  output logic [4:0] o_pos_m,
  output logic [4:0] o_pos_l
);

  logic w_adv_m;
  logic w_adv_l;

  // Middle also moves when it sits on its own notch: the historical double step
  assign w_adv_m = (i_pos_r == i_notch_r) || (i_pos_m == i_notch_m);
  assign w_adv_l = (i_pos_m == i_notch_m);

  // Right always moves; middle and left move only when carried into
  always_comb begin
    o_pos_r = pos_inc(i_pos_r);
    o_pos_m = w_adv_m ? pos_inc(i_pos_m) : i_pos_m;
    o_pos_l = w_adv_l ? pos_inc(i_pos_l) : i_pos_l;
  end

endmodule

// File: rtl/key_stepper.sv
// rtl/key_stepper.sv - keypress FSM: steps the rotors then emits the one-hot letter
module key_stepper
  import enigma_pkg::*;
(
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic        key_valid,
  input  logic [4:0]  key_code,
  input  logic [2:0]  wheel_config,
  input  logic        load,
  input  logic [14:0] load_pos,
  output logic        key_ready,
  output logic [25:0] letter_out,
  output logic        letter_valid,
  output logic [4:0]  state1,
  output logic [4:0]  state2,
  output logic [4:0]  state3
);

  state_t     r_state;
  state_t     w_state_next;
  logic [4:0] r_pos_r;
  logic [4:0] r_pos_m;
  logic [4:0] r_pos_l;
  logic [4:0] r_code;

  logic [4:0]  w_next_r;
  logic [4:0]  w_next_m;
  logic [4:0]  w_next_l;
  logic [4:0]  w_notch_r;
  logic [4:0]  w_notch_m;
  logic        w_key_ok;
  logic [25:0] w_onehot;

  assign w_key_ok  = key_valid && (key_code <= LAST_POS);
  assign w_notch_r = rotor_notch(wheel_order(wheel_config).right);
  assign w_notch_m = rotor_notch(wheel_order(wheel_config).middle);
  assign w_onehot  = 26'd1 << r_code;

  rotor_advance u_rotor_advance (
    .i_pos_r   (r_pos_r),
    .i_pos_m   (r_pos_m),
    .i_pos_l   (r_pos_l),
    .i_notch_r (w_notch_r),
    .i_notch_m (w_notch_m),
    .o_pos_r   (w_next_r),
    .o_pos_m   (w_next_m),
    .o_pos_l   (w_next_l)
  );

  // State register
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  // Next state: load holds IDLE, a legal key starts STEP, STEP and EMIT last one cycle each
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (!load && w_key_ok) w_state_next = ST_STEP;
      ST_STEP: w_state_next = ST_EMIT;
      ST_EMIT: w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Positions and latched key: loaded or latched in IDLE, stepped on the STEP->EMIT edge
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_pos_r <= 5'd0;
      r_pos_m <= 5'd0;
      r_pos_l <= 5'd0;
      r_code  <= 5'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (load) begin
            r_pos_r <= pos_sanitize(load_pos[4:0]);
            r_pos_m <= pos_sanitize(load_pos[9:5]);
            r_pos_l <= pos_sanitize(load_pos[14:10]);
          end else if (w_key_ok) begin
            r_code <= key_code;
          end
        end
        ST_STEP: begin
          r_pos_r <= w_next_r;
          r_pos_m <= w_next_m;
          r_pos_l <= w_next_l;
        end
        default: ;
      endcase
    end
  end

  // Outputs decoded from state so reset clears them without waiting for a clock
  always_comb begin
    key_ready    = 1'b0;
    letter_valid = 1'b0;
    letter_out   = 26'd0;
    case (r_state)
      ST_IDLE: key_ready = 1'b1;
      ST_EMIT: begin
        letter_valid = 1'b1;
        letter_out   = w_onehot;
      end
      default: ;
    endcase
  end

  assign state1 = r_pos_r;
  assign state2 = r_pos_m;
  assign state3 = r_pos_l;

endmodule
